// File: rtl/l2_bank_port_arbiter.sv
// Shares one L2 bank port among NUM_REQ TCDM requesters with two-class round-robin and starvation escape.
// Latency: the grant is combinational in the request cycle, and r_valid arrives one cycle after the handshake.
// Backpressure: mem_gnt_i=0 stalls every requester, and requests hold until granted. L2_ARB_PERF_CNT_EN adds grant counters.
module l2_bank_port_arbiter #(
    parameter int                 NUM_REQ      = 6,
    parameter int                 ADDR_WIDTH   = 32,
    parameter int                 DATA_WIDTH   = 32,
    parameter int                 BE_WIDTH     = DATA_WIDTH / 8,
    parameter logic [NUM_REQ-1:0] PRIO_MASK    = 6'b110000,
    parameter int                 STARVE_LIMIT = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    add_i,
    input  logic [NUM_REQ-1:0]               wen_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_REQ*BE_WIDTH-1:0]      be_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               r_valid_o,
    output logic [DATA_WIDTH-1:0]            r_rdata_o,
    output logic                             mem_req_o,
    output logic [ADDR_WIDTH-1:0]            mem_add_o,
    output logic                             mem_wen_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    output logic [BE_WIDTH-1:0]              mem_be_o,
    input  logic                             mem_gnt_i,
    input  logic                             mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i
`ifdef L2_ARB_PERF_CNT_EN
    ,
    input  logic                             perf_clr_i,
    output logic [NUM_REQ*32-1:0]            grant_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    idx_t                 rr_ptr_q;
    logic [7:0]           wait_cnt_q [NUM_REQ];
    logic                 resp_pend_q;
    idx_t                 resp_id_q;
    logic [NUM_REQ-1:0]   req_hold_q;

    logic [NUM_REQ-1:0]   starved, hi_req, lo_req, sel_mask;
    idx_t                 win;
    logic                 any_req, hs;

    // First set bit of mask at or after ptr, scanning cyclically.
    function automatic idx_t rr_pick(input logic [NUM_REQ-1:0] mask, input idx_t ptr);
        idx_t res;
        logic found;
        int   j;
        res   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && mask[j]) begin
                found = 1'b1;
                res   = idx_t'(j);
            end
        end
        return res;
    endfunction

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = req_i[i] && (wait_cnt_q[i] >= 8'(STARVE_LIMIT));
        end
        hi_req = req_i & PRIO_MASK;
        lo_req = req_i & ~PRIO_MASK;
        if (|starved)     sel_mask = starved;
        else if (|hi_req) sel_mask = hi_req;
        else              sel_mask = lo_req;
        win = rr_pick(sel_mask, rr_ptr_q);
    end

    assign any_req   = !rst_i && (|req_i);
    assign hs        = any_req && mem_gnt_i;
    assign mem_req_o = any_req;
    assign gnt_o     = hs ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        mem_add_o   = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (any_req) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win == idx_t'(i)) begin
                    mem_add_o   = add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wen_o   = wen_i[i];
                    mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                    mem_be_o    = be_i[i*BE_WIDTH +: BE_WIDTH];
                end
            end
        end
    end

    // The bank never responds without a handshake, so a stray rvalid is masked by resp_pend_q.
    assign r_valid_o = (!rst_i && resp_pend_q && mem_rvalid_i) ? (NUM_REQ'(1) << resp_id_q) : '0;
    assign r_rdata_o = mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            resp_pend_q <= 1'b0;
            resp_id_q   <= '0;
            req_hold_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt_q[i] <= '0;
        end else begin
            if (hs) begin
                rr_ptr_q  <= (win == idx_t'(NUM_REQ-1)) ? '0 : win + idx_t'(1);
                resp_id_q <= win;
            end
            resp_pend_q <= hs;
            req_hold_q  <= req_i & ~gnt_o;
            // Bank stalls count as waiting, so a stalled low-class port still ages toward a forced grant.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_i[i] || gnt_o[i])
                    wait_cnt_q[i] <= '0;
                else if (wait_cnt_q[i] < 8'(STARVE_LIMIT))
                    wait_cnt_q[i] <= wait_cnt_q[i] + 8'd1;
            end
        end
    end

    // A request withdrawn before its grant breaks the TCDM handshake.
    assert property (@(posedge clk_i) disable iff (rst_i) (req_hold_q & ~req_i) == '0);

`ifdef L2_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt_q [NUM_REQ];

    always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr_i) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_o[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
    end
`endif

endmodule

// File: doc/l2_bank_port_arbiter.md
Name: l2_bank_port_arbiter

Overview:
Shares one 32-bit L2 SRAM bank port between several TCDM requesters: the four AXI-to-TCDM bridge ports and the two uDMA TCDM channels. It uses a two-class round-robin scheme with starvation protection, so bursty uDMA traffic cannot lock out core accesses, and the reverse.
It sits between the requester-side TCDM buses and each bank inside the L2 subsystem, one instance per bank. It tracks the single outstanding response per bank and routes it back to the requester that issued the access.

Parameters:
NUM_REQ, 6, number of requesters; index 0..3 are AXI bridge ports, 4..5 are uDMA channels
ADDR_WIDTH, 32, byte address width passed through to the bank
DATA_WIDTH, 32, bank data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
PRIO_MASK, 6'b110000, bit i = 1 puts requester i in the high-priority class
STARVE_LIMIT, 8, wait cycles after which a pending low-class requester is force-granted; range 1..255

Ports:
clk_i  in  1  clock (SoC clock)
rst_i  in  1  synchronous, active-high reset
req_i  in  NUM_REQ  per-requester request, held until granted
add_i  in  NUM_REQ*ADDR_WIDTH  per-requester address
wen_i  in  NUM_REQ  1 = read, 0 = write
wdata_i  in  NUM_REQ*DATA_WIDTH  write data
be_i  in  NUM_REQ*BE_WIDTH  byte enables
gnt_o  out  NUM_REQ  one-hot grant
r_valid_o  out  NUM_REQ  one-hot response valid
r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
mem_req_o  out  1  bank request
mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o  out  ADDR_WIDTH/1/DATA_WIDTH/BE_WIDTH  fields of the winning requester
mem_gnt_i  in  1  bank accepts the request this cycle
mem_rvalid_i  in  1  bank response, exactly 1 cycle after the handshake, for reads and writes
mem_rdata_i  in  DATA_WIDTH  bank read data

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high. All state is sampled on the rising edge of clk_i.
- State:
  - rr_ptr: $clog2(NUM_REQ) bits, reset 0.
  - wait_cnt[i]: 8 bits each, reset 0.
  - resp_pend: 1 bit, reset 0.
  - resp_id: $clog2(NUM_REQ) bits, reset 0.
- Outputs while rst_i = 1: gnt_o = 0, mem_req_o = 0, r_valid_o = 0, mem_* data fields = 0, r_rdata_o = mem_rdata_i.
- Arbitration is combinational in the same cycle. Winner selection, in order:
  1. Starved set: requesters with req_i=1 and wait_cnt >= STARVE_LIMIT. If non-empty, pick the first index at or after rr_ptr, cyclically.
  2. Else high-class requests (req_i & PRIO_MASK). Pick the first index at or after rr_ptr, cyclically.
  3. Else low-class requests. Pick the first index at or after rr_ptr, cyclically.
- mem_req_o = |req_i. The mem_* fields are those of the winner, and are all 0 when there is no request.
- gnt_o[w] = mem_gnt_i for winner w; gnt_o is 0 for every other requester. A handshake is mem_req_o & mem_gnt_i.
- On a handshake: rr_ptr <= (w+1) mod NUM_REQ, resp_pend <= 1, resp_id <= w. With no handshake, resp_pend <= 0.
- wait_cnt[i]:
  - Cleared when i is granted or req_i[i] = 0.
  - Otherwise incremented by 1, saturating at STARVE_LIMIT.
  - A mem_gnt_i = 0 cycle still counts as a wait cycle for every pending requester.
- Response path: r_valid_o[resp_id] = mem_rvalid_i & resp_pend. r_rdata_o = mem_rdata_i.
- Throughput: back-to-back grants every cycle are legal. Response latency is 1 cycle after the grant.
- Boundary cases:
  - No requests: rr_ptr and all counters hold, except wait_cnt of non-requesting ports, which reads 0.
  - Single requester: granted every cycle that mem_gnt_i = 1.
  - Reset asserted while a response is pending: the response is dropped, resp_pend = 0, and a mem_rvalid_i in the next cycle is ignored.
  - mem_rvalid_i without resp_pend: ignored.
  - A requester that deasserts req_i before its grant is a protocol violation. The block does not need to handle it; an assertion flags it.

Optional Feature:
Macro L2_ARB_PERF_CNT_EN.
- Defined: adds ports perf_clr_i (in, 1) and grant_cnt_o (out, NUM_REQ*32).
  - One 32-bit counter per requester, incremented on each handshake won by that requester, wrapping at 2^32.
  - Cleared by rst_i or perf_clr_i. If perf_clr_i and a grant occur in the same cycle, the clear wins and the count is 0.
- Undefined: these ports and counters do not exist, and arbitration is identical.

Test Plan:
- Reset: hold rst_i = 1 for 3 cycles with all req_i = 1 -> gnt_o = 0, mem_req_o = 0, r_valid_o = 0. First post-reset grant goes to requester 4 (high class, first at/after rr_ptr = 0).
- Round-robin within the low class: req_i = 6'b001111, mem_gnt_i = 1 constantly -> grant order 0,1,2,3,0. The read issued by port 1 returns r_valid_o = 6'b000010 one cycle later, with r_rdata_o = mem_rdata_i.
- Starvation: req_i[4] and req_i[0] held, mem_gnt_i = 1, STARVE_LIMIT = 8 -> port 4 is granted 8 consecutive cycles, then port 0 is granted, then port 4 again.
- Bank stall: req_i = 6'b000011, mem_gnt_i = 0 for 5 cycles -> gnt_o = 0, rr_ptr unchanged, wait_cnt[0] and wait_cnt[1] = 5. Raise mem_gnt_i -> port 0 is granted first.
- Reset mid-response: handshake on port 2 in cycle N, rst_i = 1 in cycle N+1 with mem_rvalid_i = 1 -> r_valid_o = 0.
- With L2_ARB_PERF_CNT_EN: 10 grants to port 5, then perf_clr_i pulsed coinciding with an 11th grant -> grant_cnt_o[5] reads 10, then 0.
